// File: rtl/fcvt_sequencer.sv
// Multi-cycle controller for the FCVTD int<->double datapath: latches a request,
// unpacks the double operand, drives the datapath from registers, returns a registered result.
module fcvt_sequencer #(
  parameter int unsigned EXP_BIAS = 1023,
  parameter int unsigned SIG_W    = 53
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [2:0]       rm_i,
  input  logic [2:0]       frm_i,
  input  logic [63:0]      rs1_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [63:0]      result_o,
  output logic             nv_o,
  output logic             illegal_o,
  output logic [63:0]      cvtRs1_o,
  output logic [12:0]      cvtExp_o,
  output logic [SIG_W-1:0] cvtSig_o,
  output logic [5:0]       cvtClass_o,
  output logic [1:0]       cvtInstr_o,
  output logic [2:0]       cvtRm_o,
  input  logic [63:0]      cvtOut_i
);

  localparam int unsigned XLEN    = 64;
  localparam int unsigned EXP_W   = 13;
  localparam int unsigned BEXP_W  = 11;
  localparam int unsigned FRAC_W  = 52;
  localparam int unsigned CLASS_W = 6;

  // One-hot class bit positions shared with the FPU class flags
  localparam int unsigned CLS_ZERO = 0;
  localparam int unsigned CLS_SUB  = 1;
  localparam int unsigned CLS_NORM = 2;
  localparam int unsigned CLS_INF  = 3;
  localparam int unsigned CLS_QNAN = 4;
  localparam int unsigned CLS_SNAN = 5;

  localparam int unsigned OP_UNS = 0;
  localparam int unsigned OP_D2I = 1;

  localparam logic [2:0] RM_DYN       = 3'b111;
  localparam logic [2:0] RM_LAST_OKAY = 3'd4;

  localparam logic signed [EXP_W-1:0] EXP_31 = EXP_W'(31);
  localparam logic signed [EXP_W-1:0] EXP_32 = EXP_W'(32);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UNPACK  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             load_cvt;
  logic             load_res;
  logic [2:0]       rm_res;
  logic             rm_reserved;

  logic [1:0]       op_q;
  logic [2:0]       rm_q;
  logic [XLEN-1:0]  rs1_q;

  logic [BEXP_W-1:0]  bexp;
  logic [FRAC_W-1:0]  frac;
  logic               e_zero;
  logic               e_max;
  logic               frac_zero;
  logic [EXP_W-1:0]   exp_d;
  logic [SIG_W-1:0]   sig_d;
  logic [CLASS_W-1:0] class_d;

  logic signed [EXP_W-1:0] exp_s;
  logic                    sign;
  logic                    nan_inf;
  logic                    min_int;
  logic                    nv_d;

  assign rm_res      = (rm_i == RM_DYN) ? frm_i : rm_i;
  assign rm_reserved = (rm_res > RM_LAST_OKAY);

  // Field extraction from the latched operand
  assign bexp      = rs1_q[XLEN-2 -: BEXP_W];
  assign frac      = rs1_q[FRAC_W-1:0];
  assign e_zero    = (bexp == '0);
  assign e_max     = (bexp == '1);
  assign frac_zero = (frac == '0);

  // Zero/subnormal share the minimum normal exponent; Inf/NaN fall out as e-bias = +1024
  assign exp_d = e_zero ? (EXP_W'(1) - EXP_W'(EXP_BIAS))
                        : (EXP_W'(bexp) - EXP_W'(EXP_BIAS));
  assign sig_d = SIG_W'({~e_zero, frac});

  always_comb begin
    class_d           = '0;
    class_d[CLS_ZERO] = e_zero & frac_zero;
    class_d[CLS_SUB]  = e_zero & ~frac_zero;
    class_d[CLS_NORM] = ~e_zero & ~e_max;
    class_d[CLS_INF]  = e_max & frac_zero;
    class_d[CLS_QNAN] = e_max & frac[FRAC_W-1];
    class_d[CLS_SNAN] = e_max & ~frac[FRAC_W-1] & ~frac_zero;
  end

  // Invalid flag evaluated from the operands the datapath is seeing in CONVERT
  assign exp_s   = $signed(cvtExp_o);
  assign sign    = cvtRs1_o[XLEN-1];
  assign nan_inf = cvtClass_o[CLS_INF] | cvtClass_o[CLS_QNAN] | cvtClass_o[CLS_SNAN];
  assign min_int = sign && (exp_s == EXP_31) && (cvtSig_o[SIG_W-2:0] == '0);

  always_comb begin
    nv_d = 1'b0;
    if (cvtInstr_o[OP_D2I]) begin
      if (nan_inf) begin
        nv_d = 1'b1;
      end else if (!cvtInstr_o[OP_UNS]) begin
        nv_d = (exp_s >= EXP_31) && !min_int;
      end else begin
        nv_d = (exp_s >= EXP_32) || (sign && !exp_s[EXP_W-1]);
      end
    end
  end

  // Next-state and load enables
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_cvt = 1'b0;
    load_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept  = 1'b1;
          state_d = rm_reserved ? DONE : UNPACK;
        end
      end
      UNPACK: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          load_cvt = 1'b1;
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          load_res = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with status outputs that follow the state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d != IDLE);
      done_o  <= (state_d == DONE);
    end
  end

  // Request latch, datapath operand registers and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q       <= '0;
      rm_q       <= '0;
      rs1_q      <= '0;
      cvtRs1_o   <= '0;
      cvtExp_o   <= '0;
      cvtSig_o   <= '0;
      cvtClass_o <= '0;
      cvtInstr_o <= '0;
      cvtRm_o    <= '0;
      result_o   <= '0;
      nv_o       <= 1'b0;
      illegal_o  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op_i;
        rm_q  <= rm_res;
        rs1_q <= rs1_i;
        if (rm_reserved) begin
          result_o  <= '0;
          nv_o      <= 1'b0;
          illegal_o <= 1'b1;
        end
      end
      if (load_cvt) begin
        cvtRs1_o   <= rs1_q;
        cvtExp_o   <= exp_d;
        cvtSig_o   <= sig_d;
        cvtClass_o <= class_d;
        cvtInstr_o <= op_q;
        cvtRm_o    <= rm_q;
      end
      if (load_res) begin
        result_o  <= cvtOut_i;
        nv_o      <= nv_d;
        illegal_o <= 1'b0;
      end
    end
  end

endmodule
